// File: rtl/serial_tx.sv
// Serial frame transmitter: FLAG_ONES-long flag, separator zero, bit-stuffed MSB-first payload, gap zero.
// States: IDLE wait for word | FLAG flag ones | SEP separator 0 | DATA payload bit | STUFF inserted 0 | GAP trailer 0, frame_done
module serial_tx #(
    parameter int WIDTH     = 8,
    parameter int FLAG_ONES = 4,
    parameter int RUN_MAX   = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] data_in,
    input  logic             data_valid,
    output logic             data_ready,
    output logic             ostream,
    output logic             busy,
    output logic             frame_done
);

    localparam int BW = $clog2(WIDTH + 1);
    localparam int RW = $clog2(RUN_MAX + 1);
    localparam int FW = $clog2(FLAG_ONES + 1);

    typedef enum logic [2:0] {IDLE, FLAG, SEP, DATA, STUFF, GAP} state_t;

    state_t           state;
    logic [WIDTH-1:0] shreg;
    logic [BW-1:0]    bit_cnt;
    logic [RW-1:0]    run_cnt;
    logic [FW-1:0]    flag_cnt;

    logic          accept;
    logic          next_bit;
    logic [RW-1:0] run_base;
    logic [RW-1:0] run_inc;

    assign accept   = data_valid && data_ready;
    assign next_bit = shreg[WIDTH-1];
    // Entering DATA from SEP or STUFF always starts a fresh run.
    assign run_base = (state == DATA) ? run_cnt : '0;
    assign run_inc  = !next_bit ? '0 :
                      (run_base == RW'(RUN_MAX)) ? run_base : run_base + RW'(1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            shreg      <= '0;
            bit_cnt    <= '0;
            run_cnt    <= '0;
            flag_cnt   <= '0;
            ostream    <= 1'b0;
            data_ready <= 1'b0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            case (state)
                IDLE, GAP: begin
                    if (accept) begin
                        state      <= FLAG;
                        shreg      <= data_in;
                        bit_cnt    <= '0;
                        run_cnt    <= '0;
                        flag_cnt   <= '0;
                        ostream    <= 1'b1;
                        data_ready <= 1'b0;
                        busy       <= 1'b1;
                    end else begin
                        state      <= IDLE;
                        ostream    <= 1'b0;
                        data_ready <= 1'b1;
                        busy       <= 1'b0;
                    end
                end
                FLAG: begin
                    if (flag_cnt == FW'(FLAG_ONES - 1)) begin
                        state   <= SEP;
                        ostream <= 1'b0;
                        run_cnt <= '0;
                    end else begin
                        flag_cnt <= flag_cnt + FW'(1);
                        ostream  <= 1'b1;
                    end
                end
                SEP, DATA, STUFF: begin
                    if (state == DATA && run_cnt == RW'(RUN_MAX)) begin
                        state   <= STUFF;
                        ostream <= 1'b0;
                        run_cnt <= '0;
                    end else if (state != SEP && bit_cnt == BW'(WIDTH)) begin
                        state      <= GAP;
                        ostream    <= 1'b0;
                        data_ready <= 1'b1;
                        frame_done <= 1'b1;
                    end else begin
                        // Each move into DATA consumes one payload bit onto the line.
                        state   <= DATA;
                        ostream <= next_bit;
                        shreg   <= shreg << 1;
                        bit_cnt <= bit_cnt + BW'(1);
                        run_cnt <= run_inc;
                    end
                end
                default: begin
                    state      <= IDLE;
                    ostream    <= 1'b0;
                    data_ready <= 1'b0;
                    busy       <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_tx.sv
// Scoreboard bench for serial_tx: a frame-level model predicts every line cycle, a monitor pops and compares.
module tb_serial_tx;

    localparam int WIDTH     = 8;
    localparam int FLAG_ONES = 4;
    localparam int RUN_MAX   = 3;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [WIDTH-1:0] data_in = '0;
    logic             data_valid = 1'b0;
    logic             data_ready;
    logic             ostream;
    logic             busy;
    logic             frame_done;

    serial_tx #(.WIDTH(WIDTH), .FLAG_ONES(FLAG_ONES), .RUN_MAX(RUN_MAX)) dut (
        .clk        (clk),
        .rst        (rst),
        .data_in    (data_in),
        .data_valid (data_valid),
        .data_ready (data_ready),
        .ostream    (ostream),
        .busy       (busy),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic o;
        logic r;
        logic b;
        logic d;
        logic f;
    } exp_t;

    exp_t             sb[$];
    logic [WIDTH-1:0] q_w[$];
    int               q_g[$];
    int               errors = 0;
    int               checks = 0;
    bit               mon_en = 1'b0;
    int               run = 0;
    int               cyc = 0;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s (cycle %0d): got %0h want %0h", nm, cyc, got, want);
        end
    endtask

    task automatic push_idle(input int n);
        exp_t e;
        e = '{o: 1'b0, r: 1'b1, b: 1'b0, d: 1'b0, f: 1'b0};
        for (int i = 0; i < n; i++) sb.push_back(e);
    endtask

    // Line bits straight from the framing rules; returns the frame length.
    task automatic push_frame(input logic [WIDTH-1:0] w, output int n);
        logic bq[$];
        logic fq[$];
        int   r;
        exp_t e;
        r = 0;
        for (int i = 0; i < FLAG_ONES; i++) begin bq.push_back(1'b1); fq.push_back(1'b1); end
        bq.push_back(1'b0); fq.push_back(1'b0);
        for (int i = WIDTH - 1; i >= 0; i--) begin
            bq.push_back(w[i]); fq.push_back(1'b0);
            r = w[i] ? r + 1 : 0;
            if (r == RUN_MAX) begin bq.push_back(1'b0); fq.push_back(1'b0); r = 0; end
        end
        bq.push_back(1'b0); fq.push_back(1'b0);
        n = bq.size();
        for (int j = 0; j < n; j++) begin
            e = '{o: bq[j], r: (j == n - 1), b: 1'b1, d: (j == n - 1), f: fq[j]};
            sb.push_back(e);
        end
    endtask

    // Entry: #1 after a posedge, DUT idle with data_ready=1, current cycle not yet queued.
    task automatic play();
        int n;
        int g;
        push_idle(1);
        data_in    = q_w[0];
        data_valid = 1'b1;
        for (int i = 0; i < q_w.size(); i++) begin
            @(posedge clk); #1;
            push_frame(q_w[i], n);
            g = (i == q_w.size() - 1) ? 2 : q_g[i];
            if (g >= 0) push_idle(g + 1);
            data_valid = (g < 0);
            data_in    = (g < 0) ? q_w[i+1] : WIDTH'($urandom);
            repeat (n - 1) @(posedge clk);
            #1;
            if (g >= 0) begin
                repeat (g + 1) @(posedge clk);
                #1;
                if (i < q_w.size() - 1) begin
                    data_in    = q_w[i+1];
                    data_valid = 1'b1;
                end
            end
        end
        @(posedge clk); #1;
        q_w.delete();
        q_g.delete();
    endtask

    task automatic monitor();
        exp_t e;
        forever begin
            @(negedge clk);
            cyc++;
            if (mon_en && sb.size() > 0) begin
                e = sb.pop_front();
                chk("line o/ready/busy/done", {28'd0, ostream, data_ready, busy, frame_done},
                    {28'd0, e.o, e.r, e.b, e.d});
                run = ostream ? run + 1 : 0;
                chk("run_gt_RUN_MAX_outside_flag", {31'd0, (run > RUN_MAX) && !e.f}, 32'd0);
            end
        end
    endtask

    initial begin
        fork
            monitor();
        join_none

        #3;
        chk("reset ostream", {31'd0, ostream}, 32'd0);
        chk("reset data_ready", {31'd0, data_ready}, 32'd0);
        chk("reset busy", {31'd0, busy}, 32'd0);
        chk("reset frame_done", {31'd0, frame_done}, 32'd0);
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;
        chk("ready after release", {31'd0, data_ready}, 32'd1);
        mon_en = 1'b1;

        q_w = '{8'hA5, 8'hFF, 8'hEE, 8'h00, 8'h0F};
        q_g = '{2, 1, 3, -1, 2};
        play();

        // Reset during the 3rd payload bit of 0xFF (line cycle 8 after accept).
        mon_en     = 1'b0;
        data_in    = 8'hFF;
        data_valid = 1'b1;
        @(posedge clk); #1;
        data_valid = 1'b0;
        repeat (7) @(posedge clk);
        #2;
        chk("mid-frame payload bit", {31'd0, ostream}, 32'd1);
        chk("mid-frame busy", {31'd0, busy}, 32'd1);
        rst = 1'b1;
        #1;
        chk("async rst ostream", {31'd0, ostream}, 32'd0);
        chk("async rst data_ready", {31'd0, data_ready}, 32'd0);
        chk("async rst busy", {31'd0, busy}, 32'd0);
        chk("async rst frame_done", {31'd0, frame_done}, 32'd0);
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;
        chk("ready after mid-frame release", {31'd0, data_ready}, 32'd1);
        chk("busy after mid-frame release", {31'd0, busy}, 32'd0);
        run    = 0;
        mon_en = 1'b1;

        q_w = '{8'h81};
        q_g = '{2};
        play();

        for (int i = 0; i < 256; i++) begin
            q_w.push_back(WIDTH'($urandom));
            q_g.push_back(int'($urandom_range(0, 4)) - 1);
        end
        play();

        repeat (4) @(posedge clk);
        #1;
        chk("scoreboard drained", sb.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
